// File: rtl/led_pattern_engine.sv
// led_pattern_engine: prescaled step tick driving COUNT / CHASE / BREATHE / OFF patterns
// onto six active-low LEDs. BREATHE is compiled in only when LED_BREATHE_EN is defined.
module led_pattern_engine #(
    parameter int STEP_DIV = 2700000,
    parameter int PWM_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    output logic [5:0] led,
    output logic       step_tick
);

    localparam int               DIV_W    = $clog2(STEP_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    localparam logic [1:0] MODE_COUNT   = 2'd0;
    localparam logic [1:0] MODE_CHASE   = 2'd1;
    localparam logic [1:0] MODE_BREATHE = 2'd2;
    localparam logic [1:0] MODE_OFF     = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [5:0]       pat_q, pat_d;
    logic [2:0]       pos_q, pos_d;
    logic             dir_q, dir_d;
    logic [5:0]       led_q, led_d;
    logic             step_tick_q, step_tick_d;

    logic             tick;
    logic             mode_chg;
    logic [2:0]       pos_step;
    logic [5:0]       lit;

`ifdef LED_BREATHE_EN
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] duty_step;
    logic                ramp_q, ramp_d;
`endif

    always_comb begin
        tick        = (div_cnt_q == DIV_LAST);
        div_cnt_d   = tick ? '0 : div_cnt_q + DIV_W'(1);
        step_tick_d = tick;

        // A mode change reloads the pattern; a tick landing on the same edge is dropped.
        mode_chg = (mode != mode_q);
        mode_d   = mode;

        pat_d    = pat_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        pos_step = (dir_q == DIR_UP) ? pos_q + 3'd1 : pos_q - 3'd1;

        if (mode_chg) begin
            pat_d = '0;
            pos_d = '0;
            dir_d = DIR_UP;
        end else if (tick) begin
            if (mode_q == MODE_COUNT) begin
                pat_d = pat_q + 6'd1;
            end
            if (mode_q == MODE_CHASE) begin
                pos_d = pos_step;
                if (pos_step == 3'd5) begin
                    dir_d = DIR_DOWN;
                end else if (pos_step == 3'd0) begin
                    dir_d = DIR_UP;
                end
            end
        end

`ifdef LED_BREATHE_EN
        pwm_cnt_d = (mode_chg || (mode_q != MODE_BREATHE)) ? '0 : pwm_cnt_q + PWM_BITS'(1);
        duty_d    = duty_q;
        ramp_d    = ramp_q;
        duty_step = (ramp_q == DIR_UP) ? duty_q + PWM_BITS'(1) : duty_q - PWM_BITS'(1);
        if (mode_chg) begin
            duty_d = '0;
            ramp_d = DIR_UP;
        end else if (tick && (mode_q == MODE_BREATHE)) begin
            duty_d = duty_step;
            if (duty_step == DUTY_MAX) begin
                ramp_d = DIR_DOWN;
            end else if (duty_step == '0) begin
                ramp_d = DIR_UP;
            end
        end
`endif

        // Built from next-state values so led shows a new step alongside its step_tick.
        lit = '0;
        case (mode_q)
            MODE_COUNT:   lit = pat_d;
            MODE_CHASE:   lit = 6'b000001 << pos_d;
`ifdef LED_BREATHE_EN
            MODE_BREATHE: lit = (pwm_cnt_d < duty_d) ? 6'h3f : 6'h00;
`else
            MODE_BREATHE: lit = '0;
`endif
            MODE_OFF:     lit = '0;
        endcase
        led_d = ~lit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            mode_q      <= MODE_COUNT;
            pat_q       <= '0;
            pos_q       <= '0;
            dir_q       <= DIR_UP;
            led_q       <= 6'h3f;
            step_tick_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            mode_q      <= mode_d;
            pat_q       <= pat_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            led_q       <= led_d;
            step_tick_q <= step_tick_d;
        end
    end

`ifdef LED_BREATHE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            ramp_q    <= DIR_UP;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            ramp_q    <= ramp_d;
        end
    end
`endif

    assign led       = led_q;
    assign step_tick = step_tick_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Testbench for led_pattern_engine (STEP_DIV=4, PWM_BITS=3); the expected LED image is
// derived from steps-since-mode-load arithmetic. Honours LED_BREATHE_EN for mode 2.
module tb_led_pattern_engine;

    localparam int STEP_DIV = 4;
    localparam int PWM_BITS = 3;
    localparam int DUTY_MAX = (1 << PWM_BITS) - 1;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [5:0] led;
    logic       step_tick;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int         m_edges;
    int         m_mode;
    int         m_n;
    int         m_pwm;
    logic [5:0] exp_led;
    logic       exp_tick;

    int exp_pos[12] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2};

    led_pattern_engine #(
        .STEP_DIV(STEP_DIV),
        .PWM_BITS(PWM_BITS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .led      (led),
        .step_tick(step_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [5:0] lit_of(input int md, input int n, input int pwm);
        int p;
        int duty;
        case (md)
            0: return 6'(n % 64);
            1: begin
                p = n % 10;
                if (p > 5) p = 10 - p;
                return 6'(1 << p);
            end
            2: begin
`ifdef LED_BREATHE_EN
                p    = n % (2 * DUTY_MAX);
                duty = (p <= DUTY_MAX) ? p : 2 * DUTY_MAX - p;
                return ((pwm % (1 << PWM_BITS)) < duty) ? 6'h3f : 6'h00;
`else
                duty = 0;
                return 6'h00;
`endif
            end
            default: return 6'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_edges  = 0;
        m_mode   = 0;
        m_n      = 0;
        m_pwm    = 0;
        exp_led  = 6'h3f;
        exp_tick = 1'b0;
    endtask

    task automatic model_edge(input int md);
        m_edges  = m_edges + 1;
        exp_tick = ((m_edges % STEP_DIV) == 0);
        if (md != m_mode) begin
            exp_led = ~lit_of(m_mode, 0, 0);
            m_mode  = md;
            m_n     = 0;
            m_pwm   = 0;
        end else begin
            if (exp_tick) m_n = m_n + 1;
            m_pwm   = m_pwm + 1;
            exp_led = ~lit_of(m_mode, m_n, m_pwm);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(int'(mode));
        @(negedge clk);
        check("led", {2'b00, led}, {2'b00, exp_led});
        check("step_tick", {7'b0, step_tick}, {7'b0, exp_tick});
    endtask

    initial begin
        int waited;
        int pos;
        int ticks_seen;

        model_reset();
        rst_n = 1'b1;
        mode  = 2'd0;
        #1 rst_n = 1'b0;

        // reset, then COUNT through a full 64-step wrap
        repeat (3) cycle();
        check("reset_led", {2'b00, led}, 8'h3f);
        rst_n = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            cycle();
            if (i == 4)   check("count_1", {2'b00, led}, 8'h3e);
            if (i == 8)   check("count_2", {2'b00, led}, 8'h3d);
            if (i == 12)  check("count_3", {2'b00, led}, 8'h3c);
            if (i == 256) check("count_wrap", {2'b00, led}, 8'h3f);
        end

        // CHASE bounce, switched right after a tick
        mode = 2'd1;
        for (int k = 0; k < 12; k++) begin
            waited = 0;
            do begin
                cycle();
                waited = waited + 1;
            end while (step_tick !== 1'b1 && waited < 8);
            check("chase_tick_seen", {7'b0, step_tick}, 8'd1);
            pos = 15;
            for (int i = 0; i < 6; i++) if (led[i] === 1'b0) pos = i;
            check("chase_pos", 8'(pos), 8'(exp_pos[k]));
        end

        // COUNT up to pat=5, then switch to CHASE
        mode   = 2'd0;
        waited = 0;
        do begin
            cycle();
            waited = waited + 1;
        end while (!(m_n == 5 && exp_tick) && waited < 60);
        check("count_reached_5", {2'b00, led}, 8'h3a);
        mode = 2'd1;
        cycle();
        cycle();
        check("switch_chase", {2'b00, led}, 8'h3e);
        repeat (5) cycle();

        // async reset mid-chase, between edges
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", {2'b00, led}, 8'h3f);
        check("async_rst_tick", {7'b0, step_tick}, 8'd0);
        model_reset();
        mode = 2'd2;
        repeat (2) cycle();
        rst_n = 1'b1;

        // BREATHE (or OFF-equivalent when compiled out)
        ticks_seen = 0;
        for (int i = 0; i < 140; i++) begin
            cycle();
            if (step_tick === 1'b1) ticks_seen = ticks_seen + 1;
        end
        check("breathe_ticks", 8'(ticks_seen), 8'd35);

        // OFF
        mode = 2'd3;
        repeat (20) cycle();
        check("off_led", {2'b00, led}, 8'h3f);

        // randomized mode changes
        for (int r = 0; r < 40; r++) begin
            mode = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 40)) cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
